fwd_lkp_arb: RTL and testbench

Parametrised multi-port forwarding lookup table: the next-generation forwarding LUT with configurable depth, entry width and number of forwarding lookup clients. A round-robin arbiter lets several forwarding clients share one synchronous RAM read port. Host read/write over the existing Sel/Rd_DS/Wr_RW bus, with a proper stalled Rdy_Dtack handshake. Self-initialisation after reset, and write-to-read bypass. It sits between the host bus decoder and the per-channel forwarding engines.

---
 rtl/fwd_lkp_arb.sv | 182 ++++++++++++++++++
 tb/tb_fwd_lkp_arb.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_lkp_arb.sv
// Multi-port forwarding lookup table: one synchronous RAM read port shared by a host bus
// and NPORT round-robin arbitrated lookup clients, with self-initialisation and write bypass.
module fwd_lkp_arb #(
  parameter int unsigned               ASIZE       = 8,
  parameter int unsigned               CHANNEL_NUM = 4,
  parameter int unsigned               NPORT       = 2,
  parameter logic [12+CHANNEL_NUM-1:0] INIT_VAL    = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     BusMode,
  input  logic [11:0]              Addr,
  input  logic                     Sel,
  input  logic                     Rd_DS,
  input  logic                     Wr_RW,
  input  logic [12+CHANNEL_NUM-1:0] DataIn,
  output logic [12+CHANNEL_NUM-1:0] DataOut,
  output logic                     Rdy_Dtack,
  output logic                     init_done,
  input  logic [NPORT-1:0]         fwd_req,
  input  logic [NPORT*ASIZE-1:0]   fwd_addr,
  output logic [NPORT-1:0]         fwd_gnt,
  output logic [NPORT-1:0]         fwd_vld,
  output logic [12+CHANNEL_NUM-1:0] fwd_data
);

  localparam int unsigned DW    = 12 + CHANNEL_NUM;
  localparam int unsigned DEPTH = 1 << ASIZE;
  localparam int unsigned PW    = (NPORT > 1) ? $clog2(NPORT) : 1;

  typedef enum logic [2:0] {StIdle, StWr, StRd1, StRd2, StDone} host_st_e;

  host_st_e          state_q, state_d;
  logic              op_rd_q, op_rd_d;
  logic              wr_pat, rd_pat, host_wr, host_rd;
  logic [ASIZE-1:0]  init_cnt_q;
  logic              init_done_q;
  logic [PW-1:0]     ptr_q, gnt_idx;
  logic              gnt_any;
  logic [ASIZE-1:0]  gnt_addr;
  logic [DW-1:0]     mem [DEPTH];
  logic              we;
  logic [ASIZE-1:0]  wa, ra;
  logic [DW-1:0]     wd, ram_q;
  logic              s1_host_q;
  logic [NPORT-1:0]  s1_gnt_q, fwd_vld_q;
  logic [DW-1:0]     data_out_q, fwd_data_q;

  assign wr_pat = BusMode & ({Sel, Rd_DS, Wr_RW} == 3'b010);
  assign rd_pat = BusMode & ({Sel, Rd_DS, Wr_RW} == 3'b001);

  // Host bus FSM; an access is only detected from IDLE, so a held pattern never re-triggers.
  always_comb begin
    state_d   = state_q;
    op_rd_d   = op_rd_q;
    host_wr   = 1'b0;
    host_rd   = 1'b0;
    Rdy_Dtack = 1'b1;
    unique case (state_q)
      StIdle: begin
        if (init_done_q && !rst) begin
          if (wr_pat) begin
            host_wr = 1'b1;
            op_rd_d = 1'b0;
            state_d = StWr;
          end else if (rd_pat) begin
            host_rd = 1'b1;
            op_rd_d = 1'b1;
            state_d = StRd1;
          end
        end
      end
      StWr: begin
        Rdy_Dtack = 1'b0;
        state_d   = StDone;
      end
      StRd1: state_d = StRd2;
      StRd2: begin
        Rdy_Dtack = 1'b0;
        state_d   = StDone;
      end
      StDone: begin
        Rdy_Dtack = 1'b0;
        if (op_rd_q ? !rd_pat : !wr_pat) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      op_rd_q <= 1'b0;
    end else begin
      state_q <= state_d;
      op_rd_q <= op_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      init_cnt_q  <= '0;
      init_done_q <= 1'b0;
    end else if (!init_done_q) begin
      init_cnt_q <= init_cnt_q + 1'b1;
      if (init_cnt_q == '1) init_done_q <= 1'b1;
    end
  end

  // Round-robin search starting at ptr_q; the host read port claim blocks all grants.
  always_comb begin
    int idx;
    idx     = 0;
    fwd_gnt = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (init_done_q && !rst && !host_rd) begin
      for (int k = 0; k < int'(NPORT); k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= int'(NPORT)) idx = idx - int'(NPORT);
        if (!gnt_any && fwd_req[PW'(idx)]) begin
          gnt_any             = 1'b1;
          gnt_idx             = PW'(idx);
          fwd_gnt[PW'(idx)]   = 1'b1;
        end
      end
    end
  end

  always_comb begin
    gnt_addr = '0;
    for (int i = 0; i < int'(NPORT); i++) begin
      if (fwd_gnt[i]) gnt_addr = gnt_addr | fwd_addr[i*ASIZE +: ASIZE];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (gnt_any) begin
      ptr_q <= (gnt_idx == PW'(NPORT - 1)) ? '0 : gnt_idx + 1'b1;
    end
  end

  assign we = (!init_done_q && !rst) || host_wr;
  assign wa = init_done_q ? Addr[ASIZE-1:0] : init_cnt_q;
  assign wd = init_done_q ? DataIn : INIT_VAL;
  assign ra = host_rd ? Addr[ASIZE-1:0] : gnt_addr;

  // Same-cycle write to the read address forwards the new data.
  always_ff @(posedge clk) begin
    if (we) mem[wa] <= wd;
    ram_q <= (we && (wa == ra)) ? wd : mem[ra];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_host_q  <= 1'b0;
      s1_gnt_q   <= '0;
      fwd_vld_q  <= '0;
      data_out_q <= '0;
      fwd_data_q <= '0;
    end else begin
      s1_host_q <= host_rd;
      s1_gnt_q  <= fwd_gnt;
      fwd_vld_q <= s1_gnt_q;
      if (s1_host_q) data_out_q <= ram_q;
      if (|s1_gnt_q) fwd_data_q <= ram_q;
    end
  end

  assign DataOut   = data_out_q;
  assign fwd_vld   = fwd_vld_q;
  assign fwd_data  = fwd_data_q;
  assign init_done = init_done_q;

  if (ASIZE < 12) begin : g_addr_hi
    logic unused_addr_hi;
    assign unused_addr_hi = ^Addr[11:ASIZE];
  end

endmodule

// File: tb/tb_fwd_lkp_arb.sv
// Randomised bench for fwd_lkp_arb: a cycle-level reference model predicts grants, acks and
// read data; a separate monitor pops expected results when the DUT presents them.
module tb_fwd_lkp_arb;
  localparam int ASIZE = 8;
  localparam int NPORT = 3;
  localparam logic [15:0] INIT_VAL = 16'hA5C3;

  logic        clk = 1'b0, rst = 1'b1, BusMode = 1'b0, Sel = 1'b0, Rd_DS = 1'b0, Wr_RW = 1'b0;
  logic [11:0] Addr = '0;
  logic [15:0] DataIn = '0, DataOut, fwd_data;
  logic        Rdy_Dtack, init_done;
  logic [2:0]  fwd_req = '0, fwd_gnt, fwd_vld;
  logic [23:0] fwd_addr = '0;

  always #5 clk = ~clk;

  fwd_lkp_arb #(.ASIZE(ASIZE), .CHANNEL_NUM(4), .NPORT(NPORT), .INIT_VAL(INIT_VAL)) dut (
    .clk(clk), .rst(rst), .BusMode(BusMode), .Addr(Addr), .Sel(Sel), .Rd_DS(Rd_DS),
    .Wr_RW(Wr_RW), .DataIn(DataIn), .DataOut(DataOut), .Rdy_Dtack(Rdy_Dtack),
    .init_done(init_done), .fwd_req(fwd_req), .fwd_addr(fwd_addr), .fwd_gnt(fwd_gnt),
    .fwd_vld(fwd_vld), .fwd_data(fwd_data)
  );

  typedef struct { int port; logic [15:0] data; int cyc; } fexp_t;
  typedef struct { bit rd; logic [15:0] data; int lo; } hexp_t;
  fexp_t fq[$];
  hexp_t hq[$];

  int n_vec = 0, n_err = 0, cyc = 0;
  bit chk_en = 1'b0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference model state
  logic [15:0] mem_m [256];
  int          rr = 0, since = 0;
  bit          rst_d = 1'b1;
  bit          h_act = 1'b0, h_iss = 1'b0, h_rd = 1'b0;
  int          h_len = 1, h_H = 0, h_lo = 0, h_hi = 0;
  logic [11:0] h_addr = '0;
  logic [15:0] h_data = '0;
  logic [2:0]  req_v = '0;
  logic [7:0]  req_a [3];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @cyc %0d: got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [7:0] rnd_addr();
    return ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15));
  endfunction

  task automatic drive();
    logic [2:0] p;
    rst = rst_d;
    if (h_act && (!h_iss || cyc < h_H + h_len)) begin
      BusMode = 1'b1;
      {Sel, Rd_DS, Wr_RW} = h_rd ? 3'b001 : 3'b010;
      Addr   = h_addr;
      DataIn = h_data;
    end else begin
      p       = 3'($urandom);
      BusMode = 1'($urandom);
      if (BusMode && (p == 3'b010 || p == 3'b001)) BusMode = 1'b0;
      {Sel, Rd_DS, Wr_RW} = p;
      Addr   = 12'($urandom);
      DataIn = 16'($urandom);
    end
    fwd_req = req_v;
    for (int i = 0; i < NPORT; i++) fwd_addr[i*8 +: 8] = req_a[i];
  endtask

  task automatic model();
    int t, g;
    bit init_m, iss, gok;
    logic [2:0] eg;
    t      = cyc;
    init_m = (since >= 256);
    iss    = h_act && !h_iss && init_m && !rst_d;
    gok    = !rst_d && init_m && !(iss && h_rd);
    g      = -1;
    eg     = '0;
    if (gok) begin
      for (int k = 0; k < NPORT; k++) begin
        int idx = (rr + k) % NPORT;
        if (g < 0 && req_v[idx]) g = idx;
      end
    end
    if (g >= 0) eg[g] = 1'b1;
    if (chk_en) begin
      chk("init_done", 32'(init_done), 32'(init_m));
      chk("rdy_dtack", 32'(Rdy_Dtack), (h_act && h_iss && t >= h_lo && t <= h_hi) ? 32'd0 : 32'd1);
      chk("fwd_gnt", 32'(fwd_gnt), 32'(eg));
    end
    if (iss) begin
      h_iss = 1'b1;
      h_H   = t;
      if (h_rd) begin
        h_lo = t + 2;
        h_hi = (h_len > 3) ? t + h_len : t + 3;
        hq.push_back('{1'b1, mem_m[h_addr[7:0]], h_lo});
      end else begin
        mem_m[h_addr[7:0]] = h_data;
        h_lo = t + 1;
        h_hi = (h_len > 2) ? t + h_len : t + 2;
        hq.push_back('{1'b0, 16'h0, h_lo});
      end
    end
    if (g >= 0) begin
      fq.push_back('{g, mem_m[req_a[g]], t});
      rr       = (g + 1) % NPORT;
      req_v[g] = 1'b0;
    end
    if (rst_d) begin
      since = 0;
      rr    = 0;
      foreach (mem_m[i]) mem_m[i] = INIT_VAL;
      while (fq.size() > 0 && fq[$].cyc >= t - 1) void'(fq.pop_back());
    end else begin
      since++;
    end
    if (h_act && h_iss && t >= h_hi) h_act = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    drive();
    @(negedge clk);
    model();
  endtask

  task automatic start_host(input bit rd, input logic [11:0] a, input logic [15:0] d,
                            input int len);
    h_act = 1'b1; h_iss = 1'b0; h_rd = rd; h_addr = a; h_data = d; h_len = len;
  endtask

  task automatic rand_stim();
    if (!h_act && $urandom_range(0, 3) == 0)
      start_host(1'($urandom), {4'($urandom), rnd_addr()}, 16'($urandom),
                 int'($urandom_range(1, 4)));
    for (int i = 0; i < NPORT; i++) begin
      if (!req_v[i] && $urandom_range(0, 2) == 0) begin
        req_v[i] = 1'b1;
        req_a[i] = rnd_addr();
      end
    end
  endtask

  task automatic wait_host_idle();
    for (int i = 0; i < 40 && h_act; i++) step();
    chk("host_idle_bound", 32'(h_act), 32'd0);
  endtask

  task automatic check_reset_vals();
    chk("rst_rdy_dtack", 32'(Rdy_Dtack), 32'd1);
    chk("rst_data_out", 32'(DataOut), 32'd0);
    chk("rst_fwd_gnt", 32'(fwd_gnt), 32'd0);
    chk("rst_fwd_vld", 32'(fwd_vld), 32'd0);
    chk("rst_fwd_data", 32'(fwd_data), 32'd0);
    chk("rst_init_done", 32'(init_done), 32'd0);
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or an acknowledge.
  initial begin
    fexp_t fe;
    hexp_t he;
    logic  prev = 1'b1;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        while (fq.size() > 0 && fq[0].cyc + 2 < cyc) begin
          n_vec++; n_err++;
          $display("FAIL fwd_vld_missing: port %0d result absent, required at cycle %0d",
                   fq[0].port, fq[0].cyc + 2);
          void'(fq.pop_front());
        end
        if (fwd_vld !== 3'b000) begin
          if (fq.size() == 0) begin
            chk("fwd_vld_spurious", 32'(fwd_vld), 32'd0);
          end else begin
            fe = fq.pop_front();
            chk("fwd_vld_cycle", 32'(cyc), 32'(fe.cyc + 2));
            chk("fwd_vld_port", 32'(fwd_vld), 32'd1 << fe.port);
            chk("fwd_data", 32'(fwd_data), 32'(fe.data));
          end
        end
        while (hq.size() > 0 && hq[0].lo < cyc) begin
          n_vec++; n_err++;
          $display("FAIL host_ack_missing: no Rdy_Dtack fall, required at cycle %0d", hq[0].lo);
          void'(hq.pop_front());
        end
        if (prev === 1'b1 && Rdy_Dtack === 1'b0) begin
          if (hq.size() == 0) begin
            chk("host_ack_spurious", 32'(Rdy_Dtack), 32'd1);
          end else begin
            he = hq.pop_front();
            chk("host_ack_cycle", 32'(cyc), 32'(he.lo));
            if (he.rd) chk("data_out", 32'(DataOut), 32'(he.data));
          end
        end
      end
      prev = Rdy_Dtack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    foreach (mem_m[i]) mem_m[i] = INIT_VAL;
    foreach (req_a[i]) req_a[i] = '0;
    repeat (2) step();
    chk_en = 1'b1;
    step();
    check_reset_vals();
    rst_d = 1'b0;
    repeat (260) step();

    start_host(1'b0, 12'h012, 16'h05A5, 4);
    wait_host_idle();
    start_host(1'b1, 12'h012, 16'h0000, 2);
    wait_host_idle();
    req_v[1] = 1'b1; req_a[1] = 8'd200;
    repeat (4) step();

    // Two clients held continuously: grants must alternate
    repeat (8) begin
      req_v[0] = 1'b1; req_a[0] = 8'd3;
      req_v[1] = 1'b1; req_a[1] = 8'd7;
      step();
    end
    repeat (4) step();

    // Host read claims the port in the same cycle as a lookup request
    start_host(1'b1, 12'h0A3, 16'h0000, 1);
    req_v[2] = 1'b1; req_a[2] = 8'd9;
    step();
    wait_host_idle();
    repeat (4) step();

    // Host write and lookup of the same address in one cycle
    start_host(1'b0, 12'h005, 16'h003C, 1);
    req_v[0] = 1'b1; req_a[0] = 8'd5;
    step();
    wait_host_idle();

    repeat (1500) begin
      rand_stim();
      step();
    end
    wait_host_idle();
    for (int i = 0; i < 20 && req_v != 3'b000; i++) step();

    // Reset one cycle after a grant: that lookup must never complete
    req_v[1] = 1'b1; req_a[1] = 8'd42;
    step();
    rst_d = 1'b1;
    step();
    step();
    check_reset_vals();
    rst_d = 1'b0;

    repeat (800) begin
      rand_stim();
      step();
    end
    for (int i = 0; i < 100 && (h_act || req_v != 3'b000); i++) step();
    repeat (4) step();
    chk("fwd_queue_drained", 32'(fq.size()), 32'd0);
    chk("host_queue_drained", 32'(hq.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
